// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer and the bit-level writer:
// 3-bit bit-writer command codes and the sequencer state encoding.
package i2c_pkg;

  localparam logic [2:0] BIT_CMD_IDLE   = 3'b000;
  localparam logic [2:0] BIT_CMD_START  = 3'b010;
  localparam logic [2:0] BIT_CMD_STOP   = 3'b011;
  localparam logic [2:0] BIT_CMD_DATA_0 = 3'b100;
  localparam logic [2:0] BIT_CMD_DATA_1 = 3'b101;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_DATA  = 3'd2,
    SEQ_ACK   = 3'd3,
    SEQ_STOP  = 3'd4
  } seq_state_t;

  // A data bit maps onto DATA_0/DATA_1 by its value in the LSB.
  function automatic logic [2:0] data_cmd(input logic bit_val);
    return {2'b10, bit_val};
  endfunction

endpackage

// File: rtl/i2c_master_write_seq.sv
// Byte-level I2C write sequencer: frames one byte (optional START/STOP) into
// bit-writer commands. Optional I2C_WRITE_SEQ_ACK_CHECK_EN: ACK slot drives nack.
module i2c_master_write_seq
  import i2c_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  // Request: accepted on any clock with req_valid && req_ready; req_ready is
  // high only in IDLE and the request fields are latched on that edge.
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_start,
  input  logic       req_stop,
  input  logic [7:0] req_data,
  output logic       bit_go,
  output logic [2:0] bit_command,
  input  logic       bit_finish,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output seq_state_t state_dbg
);

  seq_state_t state_q;
  logic [2:0] index_q;
  logic [7:0] data_q;
  logic       start_q;
  logic       stop_q;
  logic       go_q;
  logic [2:0] cmd_q;
  logic       done_q;
  logic       ack_to_stop;

`ifdef I2C_WRITE_SEQ_ACK_CHECK_EN
  logic nack_q;
  // A NACK forces STOP so the bus is released even for unframed bytes.
  assign ack_to_stop = stop_q | sda_in;
  assign nack        = nack_q;
  logic  unused_ok;
  assign unused_ok   = start_q;
`else
  assign ack_to_stop = stop_q;
  assign nack        = 1'b0;
  logic  unused_ok;
  assign unused_ok   = start_q ^ sda_in;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
      index_q <= 3'd7;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      go_q    <= 1'b0;
      cmd_q   <= BIT_CMD_IDLE;
      done_q  <= 1'b0;
`ifdef I2C_WRITE_SEQ_ACK_CHECK_EN
      nack_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (req_valid) begin
            data_q  <= req_data;
            start_q <= req_start;
            stop_q  <= req_stop;
            index_q <= 3'd7;
            go_q    <= 1'b1;
`ifdef I2C_WRITE_SEQ_ACK_CHECK_EN
            nack_q  <= 1'b0;
`endif
            if (req_start) begin
              state_q <= SEQ_START;
              cmd_q   <= BIT_CMD_START;
            end else begin
              state_q <= SEQ_DATA;
              cmd_q   <= data_cmd(req_data[7]);
            end
          end
        end
        SEQ_START: begin
          if (bit_finish) begin
            state_q <= SEQ_DATA;
            index_q <= 3'd7;
            cmd_q   <= data_cmd(data_q[7]);
          end
        end
        SEQ_DATA: begin
          if (bit_finish) begin
            if (index_q != 3'd0) begin
              index_q <= index_q - 3'd1;
              cmd_q   <= data_cmd(data_q[index_q - 3'd1]);
            end else begin
              state_q <= SEQ_ACK;
              cmd_q   <= BIT_CMD_DATA_1;
            end
          end
        end
        SEQ_ACK: begin
          if (bit_finish) begin
`ifdef I2C_WRITE_SEQ_ACK_CHECK_EN
            nack_q <= sda_in;
`endif
            if (ack_to_stop) begin
              state_q <= SEQ_STOP;
              cmd_q   <= BIT_CMD_STOP;
            end else begin
              state_q <= SEQ_IDLE;
              index_q <= 3'd7;
              go_q    <= 1'b0;
              cmd_q   <= BIT_CMD_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        SEQ_STOP: begin
          if (bit_finish) begin
            state_q <= SEQ_IDLE;
            index_q <= 3'd7;
            go_q    <= 1'b0;
            cmd_q   <= BIT_CMD_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
          index_q <= 3'd7;
          go_q    <= 1'b0;
          cmd_q   <= BIT_CMD_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == SEQ_IDLE);
  assign busy        = (state_q != SEQ_IDLE);
  assign bit_go      = go_q;
  assign bit_command = cmd_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_i2c_master_write_seq.sv
// Bench for i2c_master_write_seq with a bit-writer model (8 clocks per bit)
// and an sda_in model that drives the ACK-slot value.
module tb_i2c_master_write_seq;
  import i2c_pkg::*;

`ifdef I2C_WRITE_SEQ_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_start = 1'b0;
  logic       req_stop = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       bit_go;
  logic [2:0] bit_command;
  logic       bit_finish;
  logic       sda_in = 1'b0;
  logic       busy;
  logic       done;
  logic       nack;
  seq_state_t state_dbg;

  i2c_master_write_seq dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_start   (req_start),
    .req_stop    (req_stop),
    .req_data    (req_data),
    .bit_go      (bit_go),
    .bit_command (bit_command),
    .bit_finish  (bit_finish),
    .sda_in      (sda_in),
    .busy        (busy),
    .done        (done),
    .nack        (nack),
    .state_dbg   (state_dbg)
  );

  // bit-writer model and bus model
  logic [2:0] bw_cnt;
  int         bits_done;
  int         ack_idx = 8;
  bit         cur_ack = 1'b0;

  assign bit_finish = bit_go && (bw_cnt == 3'd7);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bw_cnt    <= 3'd0;
      bits_done <= 0;
    end else begin
      bw_cnt <= bit_go ? bw_cnt + 3'd1 : 3'd0;
      if (req_valid && req_ready) bits_done <= 0;
      else if (bit_finish)        bits_done <= bits_done + 1;
    end
  end

  always @(negedge clock)
    sda_in = (bits_done == ack_idx) ? cur_ack : ($urandom_range(0, 1) == 1);

  // scoreboard
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clock) begin
    if (reset_n && bit_go && bit_finish) begin
      if (exp_q.size() == 0) begin
        check("extra_bit", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bit_cmd", {29'd0, bit_command}, {29'd0, mon_exp});
      end
    end
  end

  // reference model: the command stream a request must produce
  task automatic model_push(input bit s, input bit st, input logic [7:0] d, input bit a,
                            output int lat, output bit nk);
    int n;
    n = 0;
    if (s) begin exp_q.push_back(3'b010); n++; end
    for (int i = 7; i >= 0; i--) begin exp_q.push_back({2'b10, d[i]}); n++; end
    exp_q.push_back(3'b101); n++;
    if (st || (ACK_CHK && a)) begin exp_q.push_back(3'b011); n++; end
    lat = 8 * n;
    nk  = ACK_CHK && a;
  endtask

  // drivers
  task automatic present(input bit s, input bit st, input logic [7:0] d, input bit a,
                         output int lat, output bit nk);
    int w;
    @(negedge clock);
    req_valid = 1'b1;
    req_start = s;
    req_stop  = st;
    req_data  = d;
    ack_idx   = s ? 9 : 8;
    cur_ack   = a;
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clock); w++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    model_push(s, st, d, a, lat, nk);
    @(posedge clock);
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_start = ($urandom_range(0, 1) == 1);
    req_stop  = ($urandom_range(0, 1) == 1);
    req_data  = 8'($urandom_range(0, 255));
  endtask

  // Called from just after the accept edge; counts edges until done.
  task automatic wait_done(input int lat, input bit nk, input bit tail);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (cyc == 20) begin
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("nack_clear", {31'd0, nack}, 32'd0);
      end
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", cyc, lat);
    check("nack", {31'd0, nack}, {31'd0, nk});
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("idle_go", {31'd0, bit_go}, 32'd0);
    check("idle_cmd", {29'd0, bit_command}, 32'd0);
    if (tail) begin
      @(negedge clock);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clock);
      check("nack_hold", {31'd0, nack}, {31'd0, nk});
    end
  endtask

  task automatic do_req(input bit s, input bit st, input logic [7:0] d, input bit a);
    int lat;
    bit nk;
    present(s, st, d, a, lat, nk);
    @(negedge clock);
    scramble();
    wait_done(lat, nk, 1'b1);
  endtask

  task automatic do_b2b();
    int lat1, lat2;
    bit nk1, nk2;
    logic [7:0] d2;
    d2 = 8'($urandom_range(0, 255));
    present(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, lat1, nk1);
    @(negedge clock);
    req_start = 1'b1;
    req_stop  = 1'b0;
    req_data  = d2;
    wait_done(lat1, nk1, 1'b0);
    check("b2b_ready_at_done", {31'd0, req_ready}, 32'd1);
    model_push(1'b1, 1'b0, d2, 1'b0, lat2, nk2);
    @(posedge clock);
    @(negedge clock);
    check("b2b_go", {31'd0, bit_go}, 32'd1);
    check("b2b_cmd", {29'd0, bit_command}, 32'd2);
    scramble();
    wait_done(lat2, nk2, 1'b1);
  endtask

  task automatic do_reset_mid();
    int lat, w;
    bit nk, any_done;
    present(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, lat, nk);
    @(negedge clock);
    scramble();
    w = 0;
    while (bits_done != 5 && w < 200) begin @(negedge clock); w++; end
    check("reached_idx3", bits_done, 32'd5);
    reset_n = 1'b0;
    #1;
    check("rst_go", {31'd0, bit_go}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd", {29'd0, bit_command}, 32'd0);
    exp_q.delete();
    any_done = 1'b0;
    repeat (3) begin @(negedge clock); any_done |= done; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clock); any_done |= done; end
    check("no_done_after_rst", {31'd0, any_done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_go0", {31'd0, bit_go}, 32'd0);
    check("rst_cmd0", {29'd0, bit_command}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_nack", {31'd0, nack}, 32'd0);
    check("rst_busy0", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, SEQ_IDLE});
    reset_n = 1'b1;
    @(negedge clock);

    do_req(1'b1, 1'b1, 8'hA5, 1'b0);
    do_req(1'b0, 1'b0, 8'h00, 1'b0);
    do_b2b();
    do_req(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    do_reset_mid();
    do_req(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int k = 0; k < 16; k++)
      do_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
